// File: rtl/unary_add_pkg.sv
// Shared types and constants for the unary adder scheduler.
// Pure definitions: no latency, no backpressure.
package unary_add_pkg;

    localparam int OPW          = 3;
    localparam int FLUSH_CYCLES = 2;
    localparam int DRAIN_MAX    = 9;
    localparam int CNTW         = 4;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN,
        RESP
    } state_t;

    function automatic logic [OPW-1:0] sat_inc(input logic [OPW-1:0] v);
        return (&v) ? v : v + OPW'(1);
    endfunction

endpackage

// File: rtl/unary_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from valid and last_grant.
// Pointer moves only when the caller reports an accepted grant.
module unary_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       take,
    input  logic       taken_id,
    output logic [1:0] grant
);

    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (take) begin
            last_grant <= taken_id;
        end
    end

    // On a tie the requester not served last wins; reset value favours requester 0.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/unary_add_sched.sv
// Arbitrates two requesters onto a unary adder: feed max(a,b), flush 2, drain until first 0.
// Latency ~ 2 + max(a,b) + 2 + drain cycles; rsp_ready low stalls in RESP with adder idle.
module unary_add_sched
    import unary_add_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [OPW-1:0] req0_a,
    input  logic [OPW-1:0] req0_b,
    input  logic [OPW-1:0] req1_a,
    input  logic [OPW-1:0] req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [OPW-1:0] rsp_sum,
    output logic           rsp_carry,
    output logic           add_en,
    output logic           add_rw,
    output logic           add_a,
    output logic           add_b,
    input  logic           add_dout,
    input  logic           add_c
);

    state_t          state, state_nxt;
    logic [OPW-1:0]  a_left, a_left_nxt, b_left, b_left_nxt;
    logic [OPW-1:0]  sum_cnt, sum_nxt;
    logic            carry_seen, carry_nxt;
    logic [CNTW-1:0] cyc_cnt, cyc_nxt;
    logic            owner, owner_nxt;

    logic [1:0]      req_ready_nxt;
    logic            rsp_valid_nxt, rsp_id_nxt, rsp_carry_nxt;
    logic [OPW-1:0]  rsp_sum_nxt;
    logic            add_en_nxt, add_rw_nxt, add_a_nxt, add_b_nxt;

    logic [1:0]      grant;
    logic            xfer, take, done;
    logic [OPW-1:0]  op_a, op_b;

    assign xfer = |(req_valid & req_ready);

    unary_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (req_valid),
        .take     (take),
        .taken_id (req_ready[1]),
        .grant    (grant)
    );

    // Output registers carry the values for the state being entered, so every port is a flop.
    always_comb begin
        state_nxt     = state;
        a_left_nxt    = a_left;
        b_left_nxt    = b_left;
        sum_nxt       = sum_cnt;
        carry_nxt     = carry_seen;
        cyc_nxt       = cyc_cnt;
        owner_nxt     = owner;
        req_ready_nxt = 2'b00;
        rsp_valid_nxt = rsp_valid;
        rsp_id_nxt    = rsp_id;
        rsp_sum_nxt   = rsp_sum;
        rsp_carry_nxt = rsp_carry;
        add_en_nxt    = 1'b0;
        add_rw_nxt    = 1'b0;
        add_a_nxt     = 1'b0;
        add_b_nxt     = 1'b0;
        take          = 1'b0;
        done          = 1'b0;
        op_a          = req_ready[1] ? req1_a : req0_a;
        op_b          = req_ready[1] ? req1_b : req0_b;

        case (state)
            IDLE: begin
                if (req_ready != 2'b00) begin
                    // Offer is open for exactly this cycle; operands only sampled on transfer.
                    if (xfer) begin
                        take       = 1'b1;
                        owner_nxt  = req_ready[1];
                        sum_nxt    = '0;
                        carry_nxt  = 1'b0;
                        add_en_nxt = 1'b1;
                        if (op_a == '0 && op_b == '0) begin
                            state_nxt = FLUSH;
                            cyc_nxt   = '0;
                        end else begin
                            state_nxt  = FEED;
                            add_a_nxt  = (op_a != '0);
                            add_b_nxt  = (op_b != '0);
                            a_left_nxt = (op_a != '0) ? op_a - OPW'(1) : op_a;
                            b_left_nxt = (op_b != '0) ? op_b - OPW'(1) : op_b;
                        end
                    end
                end else if (|req_valid) begin
                    req_ready_nxt = grant;
                end
            end

            FEED: begin
                carry_nxt  = carry_seen | add_c;
                add_en_nxt = 1'b1;
                if (a_left == '0 && b_left == '0) begin
                    state_nxt = FLUSH;
                    cyc_nxt   = '0;
                end else begin
                    add_a_nxt  = (a_left != '0);
                    add_b_nxt  = (b_left != '0);
                    a_left_nxt = (a_left != '0) ? a_left - OPW'(1) : a_left;
                    b_left_nxt = (b_left != '0) ? b_left - OPW'(1) : b_left;
                end
            end

            FLUSH: begin
                carry_nxt  = carry_seen | add_c;
                add_en_nxt = 1'b1;
                if (cyc_cnt == CNTW'(FLUSH_CYCLES - 1)) begin
                    state_nxt  = DRAIN;
                    add_rw_nxt = 1'b1;
                    cyc_nxt    = '0;
                end else begin
                    cyc_nxt = cyc_cnt + CNTW'(1);
                end
            end

            DRAIN: begin
                carry_nxt = carry_seen | add_c;
                // First sample predates the read command and is discarded.
                if (cyc_cnt != '0) begin
                    if (add_dout) sum_nxt = sat_inc(sum_cnt);
                    else          done    = 1'b1;
                end
                if (cyc_cnt == CNTW'(DRAIN_MAX - 1)) done = 1'b1;
                if (done) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_id_nxt    = owner;
                    rsp_sum_nxt   = sum_nxt;
                    rsp_carry_nxt = carry_nxt;
                end else begin
                    add_en_nxt = 1'b1;
                    add_rw_nxt = 1'b1;
                    cyc_nxt    = cyc_cnt + CNTW'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_left     <= '0;
            b_left     <= '0;
            sum_cnt    <= '0;
            carry_seen <= 1'b0;
            cyc_cnt    <= '0;
            owner      <= 1'b0;
            req_ready  <= 2'b00;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_carry  <= 1'b0;
            add_en     <= 1'b0;
            add_rw     <= 1'b0;
            add_a      <= 1'b0;
            add_b      <= 1'b0;
        end else begin
            state      <= state_nxt;
            a_left     <= a_left_nxt;
            b_left     <= b_left_nxt;
            sum_cnt    <= sum_nxt;
            carry_seen <= carry_nxt;
            cyc_cnt    <= cyc_nxt;
            owner      <= owner_nxt;
            req_ready  <= req_ready_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_id     <= rsp_id_nxt;
            rsp_sum    <= rsp_sum_nxt;
            rsp_carry  <= rsp_carry_nxt;
            add_en     <= add_en_nxt;
            add_rw     <= add_rw_nxt;
            add_a      <= add_a_nxt;
            add_b      <= add_b_nxt;
        end
    end

endmodule

// File: tb/tb_unary_add_sched.sv
// Directed bench for unary_add_sched with a behavioural mod-7 unary adder attached.
// Adder: write adds A+B (wrap at 7 sets a flag, seen on C one cycle later); read emits registered pulses.
module tb_unary_add_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready;
    logic [2:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [2:0] rsp_sum;
    logic       add_en, add_rw, add_a, add_b, add_dout, add_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    unary_add_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .add_en    (add_en),
        .add_rw    (add_rw),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_dout  (add_dout),
        .add_c     (add_c)
    );

    logic [2:0] acnt;
    logic       aflag;
    int         s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acnt     <= 3'd0;
            aflag    <= 1'b0;
            add_dout <= 1'b0;
            add_c    <= 1'b0;
        end else begin
            add_c <= aflag;
            if (!add_en) begin
                aflag    <= 1'b0;
                add_dout <= 1'b0;
            end else if (add_rw) begin
                add_dout <= (acnt != 3'd0);
                if (acnt != 3'd0) acnt <= acnt - 3'd1;
            end else begin
                add_dout <= 1'b0;
                s = int'(acnt) + int'(add_a) + int'(add_b);
                if (s >= 7) begin
                    acnt  <= 3'(s - 7);
                    aflag <= 1'b1;
                end else begin
                    acnt <= 3'(s);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int id, input logic [2:0] a, input logic [2:0] b);
        logic ok;
        ok = 1'b0;
        if (id == 0) begin req0_a = a; req0_b = b; end
        else         begin req1_a = a; req1_b = b; end
        req_valid[id] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin ok = 1'b1; break; end
        end
        chk("grant_seen", 32'(ok), 32'd1);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived", 32'(rsp_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int         n;
        int         ng, nr;
        logic [2:0] fa_pat;
        logic [1:0] gr [4];
        logic       rid [4];
        logic [2:0] rs [4];

        fa_pat    = 3'b011;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req0_a = 3'd0; req0_b = 3'd0; req1_a = 3'd0; req1_b = 3'd0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_sum",   32'(rsp_sum),   32'd0);
        chk("rst_add_en",    32'(add_en),    32'd0);
        chk("rst_add_rw",    32'(add_rw),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // req0 a=2 b=3, response stalled
        do_req(0, 3'd2, 3'd3);
        for (int i = 0; i < 3; i++) begin
            chk("feed_en",    32'(add_en),    32'd1);
            chk("feed_rw",    32'(add_rw),    32'd0);
            chk("feed_a",     32'(add_a),     32'(fa_pat[i]));
            chk("feed_b",     32'(add_b),     32'd1);
            chk("feed_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            chk("flush_en", 32'(add_en), 32'd1);
            chk("flush_rw", 32'(add_rw), 32'd0);
            chk("flush_ab", 32'({add_a, add_b}), 32'd0);
            @(negedge clk);
        end
        chk("drain_en", 32'(add_en), 32'd1);
        chk("drain_rw", 32'(add_rw), 32'd1);
        wait_rsp(n);
        chk("r031_lat",   32'(n),         32'd7);
        chk("r031_id",    32'(rsp_id),    32'd0);
        chk("r031_sum",   32'(rsp_sum),   32'd5);
        chk("r031_carry", 32'(rsp_carry), 32'd0);

        req_valid[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_en",    32'(add_en),    32'd0);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_sum",   32'(rsp_sum),   32'd5);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("release_idle_ready", 32'(req_ready), 32'd0);

        // req1 a=0 b=0: no FEED, 2 FLUSH, 2 DRAIN
        do_req(1, 3'd0, 3'd0);
        chk("z_flush1_en", 32'(add_en), 32'd1);
        chk("z_flush1_rw", 32'(add_rw), 32'd0);
        @(negedge clk);
        chk("z_flush2_rw", 32'(add_rw), 32'd0);
        @(negedge clk);
        chk("z_drain1_rw", 32'(add_rw), 32'd1);
        @(negedge clk);
        chk("z_drain2_rw", 32'(add_rw), 32'd1);
        @(negedge clk);
        chk("z_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("z_rsp_en",    32'(add_en),    32'd0);
        chk("z_rsp_id",    32'(rsp_id),    32'd1);
        chk("z_rsp_sum",   32'(rsp_sum),   32'd0);
        chk("z_rsp_carry", 32'(rsp_carry), 32'd0);
        @(negedge clk);
        chk("z_rsp_drop", 32'(rsp_valid), 32'd0);

        // req0 a=4 b=3: seventh unit wraps the adder to 0 and raises C
        do_req(0, 3'd4, 3'd3);
        wait_rsp(n);
        chk("c_lat",   32'(n),         32'd8);
        chk("c_id",    32'(rsp_id),    32'd0);
        chk("c_sum",   32'(rsp_sum),   32'd0);
        chk("c_carry", 32'(rsp_carry), 32'd1);
        @(negedge clk);

        // reset in the middle of DRAIN
        do_req(0, 3'd3, 3'd3);
        repeat (6) @(negedge clk);
        chk("mid_in_drain", 32'(add_rw), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_req_ready", 32'(req_ready), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_rsp_id",    32'(rsp_id),    32'd0);
        chk("mr_rsp_sum",   32'(rsp_sum),   32'd0);
        chk("mr_rsp_carry", 32'(rsp_carry), 32'd0);
        chk("mr_add",       32'({add_en, add_rw, add_a, add_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(0, 3'd1, 3'd1);
        wait_rsp(n);
        chk("ar_sum",   32'(rsp_sum),   32'd2);
        chk("ar_carry", 32'(rsp_carry), 32'd0);
        chk("ar_id",    32'(rsp_id),    32'd0);

        // both requesters valid continuously after reset
        do_reset();
        for (int k = 0; k < 4; k++) begin gr[k] = 2'b00; rid[k] = 1'bx; rs[k] = 3'bx; end
        req0_a = 3'd1; req0_b = 3'd1; req1_a = 3'd1; req1_b = 3'd1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 300 && nr < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00 && ng < 4) begin gr[ng] = req_ready; ng++; end
            if (rsp_valid) begin rid[nr] = rsp_id; rs[nr] = rsp_sum; nr++; end
        end
        req_valid = 2'b00;
        chk("rr_rsp_count", 32'(nr), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant",  32'(gr[k]),  (k % 2 == 1) ? 32'd2 : 32'd1);
            chk("rr_rsp_id", 32'(rid[k]), 32'(k % 2));
            chk("rr_sum",    32'(rs[k]),  32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
